// File: rtl/systolic_host_driver.sv
// systolic_host_driver
// Host-side sequencer for an 8x8 bit-level outer-product systolic processor.
// Operand vectors A[k] and B[k] are loaded while idle. A run resets the
// processor, streams the skewed operand columns two cycles per step, then
// pulses readout and captures the N result rows shifted out on uo_out.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   wr_en/wr_sel        operand write strobe; wr_sel 0 = A, 1 = B
//   wr_addr/wr_data     step index k and 8-bit operand vector
//   k_len               steps to run (clamped to 8)
//   usexor              accumulate mode latched at start: 1 XOR, 0 OR
//   start               run request (ignored unless idle)
//   busy, done          run in progress / one-cycle completion pulse
//   rd_addr/rd_data     combinational read of a captured result row
//   dut_ui_in           processor ui_in (feed data)
//   dut_uio_in          processor uio_in: bit0 readout, bit1 usexor
//   dut_rst_n           processor reset, low in CLR and after host reset
//   dut_uo_out          processor uo_out (result rows during readout)
module systolic_host_driver #(
  parameter int N    = 8,
  parameter int KMAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [3:0] k_len,
  input  logic       usexor,
  input  logic       start,
  output logic       busy,
  output logic       done,
  input  logic [2:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [7:0] dut_ui_in,
  output logic [7:0] dut_uio_in,
  output logic       dut_rst_n,
  input  logic [7:0] dut_uo_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t       state_r;
  logic [5:0]   cnt_r;
  logic [3:0]   k_r;
  logic         mode_r;
  logic         readout_r;
  logic         rst_n_r;
  logic [7:0]   ui_r;
  logic [N-1:0] a_r   [KMAX];
  logic [N-1:0] b_r   [KMAX];
  logic [N-1:0] res_r [N];

  logic [5:0]   feed_c_s;
  logic [4:0]   step_s;
  logic         phase_s;
  logic [2:0]   idx_s;
  logic [7:0]   feed_s;
  logic [4:0]   steps_s;
  logic         feed_last_s;
  logic [2:0]   drain_row_s;

  // Word to present in the next FEED cycle: step s = cycle/2; even cycles
  // carry the skewed A diagonal, odd cycles the skewed B diagonal.
  always_comb begin
    feed_c_s = (state_r == CLR) ? 6'd0 : (cnt_r + 6'd1);
    step_s   = feed_c_s[5:1];
    phase_s  = feed_c_s[0];
    feed_s   = 8'd0;
    idx_s    = 3'd0;
    for (int b = 0; b < 8; b++) begin
      idx_s = step_s[2:0] - 3'(b);
      // lane b carries operand k = s - b only while 0 <= k < K
      if (({1'b0, step_s} >= 6'(b)) && ({1'b0, step_s} < (6'(b) + {2'b00, k_r}))) begin
        feed_s[b] = phase_s ? b_r[idx_s][b] : a_r[idx_s][b];
      end else begin
        feed_s[b] = 1'b0;
      end
    end
  end

  // FEED length is 2*(K+2N-2) cycles; DRAIN cycle d writes row N-d (mod 8 arithmetic, N = 8).
  always_comb begin
    steps_s     = {1'b0, k_r} + 5'd14;
    feed_last_s = (cnt_r == ({steps_s, 1'b0} - 6'd1));
    drain_row_s = 3'd0 - cnt_r[2:0];
  end

  assign busy       = (state_r != IDLE);
  assign done       = (state_r == DONE);
  assign rd_data    = res_r[rd_addr];
  assign dut_ui_in  = ui_r;
  assign dut_uio_in = {6'd0, mode_r, readout_r};
  assign dut_rst_n  = rst_n_r;

  // Run sequencer, operand store and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= 6'd0;
      k_r       <= 4'd0;
      mode_r    <= 1'b0;
      readout_r <= 1'b0;
      rst_n_r   <= 1'b0;
      ui_r      <= 8'd0;
      for (int i = 0; i < KMAX; i++) begin
        a_r[i] <= '0;
        b_r[i] <= '0;
      end
      for (int i = 0; i < N; i++) begin
        res_r[i] <= '0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          rst_n_r <= 1'b1;
          if (wr_en) begin
            if (wr_sel) begin
              b_r[wr_addr] <= wr_data;
            end else begin
              a_r[wr_addr] <= wr_data;
            end
          end
          if (start) begin
            state_r <= CLR;
            k_r     <= (k_len > 4'd8) ? 4'd8 : k_len;
            mode_r  <= usexor;
            rst_n_r <= 1'b0;
          end
        end
        CLR: begin
          state_r <= FEED;
          cnt_r   <= 6'd0;
          rst_n_r <= 1'b1;
          ui_r    <= feed_s;
        end
        FEED: begin
          if (feed_last_s) begin
            state_r   <= DRAIN;
            cnt_r     <= 6'd0;
            ui_r      <= 8'd0;
            readout_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 6'd1;
            ui_r  <= feed_s;
          end
        end
        DRAIN: begin
          // d = 0 is the processor's pipeline fill cycle and is discarded
          if (cnt_r != 6'd0) begin
            res_r[drain_row_s] <= dut_uo_out;
          end
          if (cnt_r == 6'(N)) begin
            state_r   <= DONE;
            readout_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 6'd1;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_host_driver.sv
// Scoreboard bench for systolic_host_driver with a behavioural processor
// model driving dut_uo_out.
module tb_systolic_host_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0, wr_sel = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [7:0] wr_data = 8'd0;
  logic [3:0] k_len = 4'd0;
  logic       usexor = 1'b0, start = 1'b0;
  logic       busy, done;
  logic [2:0] rd_addr = 3'd0;
  logic [7:0] rd_data, dut_ui_in, dut_uio_in;
  logic       dut_rst_n;
  logic [7:0] uo = 8'd0;

  systolic_host_driver #(.N(8), .KMAX(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .k_len(k_len), .usexor(usexor),
    .start(start), .busy(busy), .done(done), .rd_addr(rd_addr),
    .rd_data(rd_data), .dut_ui_in(dut_ui_in), .dut_uio_in(dut_uio_in),
    .dut_rst_n(dut_rst_n), .dut_uo_out(uo)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // bench copy of the operand store and current run parameters
  logic [7:0] a_m [8];
  logic [7:0] b_m [8];
  int         cur_k = 0;

  typedef struct {
    logic [63:0] rows;   // row i at bits [8i +: 8]
    int          k;
    int          start;
  } exp_t;
  exp_t exp_q [$];

  int clr_req = 0, clr_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // result[i] bit j = reduction over k<K of A[k][j] & B[k][i]
  function automatic logic [63:0] ref_result(int k, logic mode);
    logic [63:0] r = 64'd0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        logic v = 1'b0;
        for (int kk = 0; kk < k; kk++)
          v = mode ? (v ^ (a_m[kk][j] & b_m[kk][i])) : (v | (a_m[kk][j] & b_m[kk][i]));
        r[i*8+j] = v;
      end
    return r;
  endfunction

  function automatic logic [7:0] skew(int s, logic use_b);
    logic [7:0] w = 8'd0;
    for (int b = 0; b < 8; b++) begin
      int idx = s - b;
      if (idx >= 0 && idx < cur_k) w[b] = use_b ? b_m[idx][b] : a_m[idx][b];
    end
    return w;
  endfunction

  // ---------------- behavioural processor model ----------------
  // Cell (i,j) sees ui bit j delayed i steps and the B word bit i delayed
  // j steps; readout shifts rows out from row 7 down, one per cycle.
  logic [7:0] in1_h [$];
  logic [7:0] in2_h [$];
  logic [7:0] acc [8];
  int pc = 0, rcnt = 0, flen, s;
  logic pa, pb;

  always @(posedge clk) begin
    flen = 2 * (cur_k + 14);
    if (!dut_rst_n) begin
      pc = 0; rcnt = 0;
      in1_h.delete(); in2_h.delete();
      for (int i = 0; i < 8; i++) acc[i] = 8'd0;
    end else if (dut_uio_in[0]) begin
      if (rcnt == 0) check("feed_len", 64'(pc), 64'(flen));
      uo <= (rcnt < 8) ? acc[7-rcnt] : 8'd0;
      rcnt++;
    end else if (busy && pc < flen) begin
      if (pc % 2 == 0) begin
        in1_h.push_back(dut_ui_in);
      end else begin
        s = pc / 2;
        in2_h.push_back(dut_ui_in);
        check("feed_step", {48'd0, in1_h[s], dut_ui_in}, {48'd0, skew(s, 1'b0), skew(s, 1'b1)});
        for (int i = 0; i < 8; i++)
          for (int j = 0; j < 8; j++)
            if (s >= i && s >= j) begin
              pa = in1_h[s-i][j];
              pb = in2_h[s-j][i];
              acc[i][j] = dut_uio_in[1] ? (acc[i][j] ^ (pa & pb)) : (acc[i][j] | (pa & pb));
            end
      end
      pc++;
    end
  end

  // ---------------- monitor ----------------
  exp_t me;
  always @(negedge clk) begin
    if (clr_req != clr_seen) begin
      clr_seen = clr_req;
      for (int r = 0; r < 8; r++) begin
        rd_addr = 3'(r);
        #1 check("rows_cleared", {56'd0, rd_data}, 64'd0);
      end
    end else if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        me = exp_q.pop_front();
        check("latency", 64'(cyc - me.start), 64'(2 * (me.k + 14) + 10));
        for (int r = 0; r < 8; r++) begin
          rd_addr = 3'(r);
          #1 check("result_row", {56'd0, rd_data}, {56'd0, me.rows[r*8 +: 8]});
        end
      end
    end else if (!busy && !reset) begin
      check("idle_outputs", {48'd0, dut_ui_in, dut_uio_in[7:2], dut_uio_in[0], 1'b0}, 64'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input logic sel, input int addr, input logic [7:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 3'(addr); wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (sel) b_m[addr] = data; else a_m[addr] = data;
  endtask

  task automatic load_random();
    for (int k = 0; k < 8; k++) begin
      wr(1'b0, k, 8'($urandom));
      wr(1'b1, k, 8'($urandom));
    end
  endtask

  task automatic run_start(input int k, input logic mode, input logic [63:0] rows);
    exp_t e;
    @(negedge clk);
    k_len = 4'(k); usexor = mode; start = 1'b1;
    cur_k = (k > 8) ? 8 : k;
    @(posedge clk); #1;
    start = 1'b0;
    e.rows = rows; e.k = cur_k; e.start = cyc;
    exp_q.push_back(e);
    check("uio_mode", {56'd0, dut_uio_in}, {56'd0, 6'd0, mode, 1'b0});
    check("busy_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("run_timeout", 64'd1, 64'd0);
  endtask

  task automatic run(input int k, input logic mode, input logic [63:0] rows);
    run_start(k, mode, rows);
    wait_idle();
  endtask

  initial begin
    int k;
    logic m;
    for (int i = 0; i < 8; i++) begin a_m[i] = 8'd0; b_m[i] = 8'd0; end

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_ui", {56'd0, dut_ui_in}, 64'd0);
    check("rst_uio", {56'd0, dut_uio_in}, 64'd0);
    check("rst_dut_rst_n", {63'd0, dut_rst_n}, 64'd0);
    clr_req++;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk);

    // K=1 single bit, OR mode: result[0]=01, others 00, 40-cycle latency
    wr(1'b0, 0, 8'h01); wr(1'b1, 0, 8'h01);
    run(1, 1'b0, 64'h0000_0000_0000_0001);

    // K=8 one-hot diagonal: result[i] = 1<<i
    for (int i = 0; i < 8; i++) begin wr(1'b0, i, 8'(1 << i)); wr(1'b1, i, 8'(1 << i)); end
    run(8, 1'b1, 64'h8040_2010_0804_0201);

    // K=2 all-ones: OR gives FF rows, XOR cancels to 00
    for (int i = 0; i < 2; i++) begin wr(1'b0, i, 8'hFF); wr(1'b1, i, 8'hFF); end
    run(2, 1'b0, {8{8'hFF}});
    run(2, 1'b1, 64'd0);

    // K=3 random operands (waveform skew checked by the processor model)
    for (int t = 0; t < 2; t++) begin
      load_random();
      m = 1'($urandom);
      run(3, m, ref_result(3, m));
    end

    // K=0 and clamped K>8
    load_random();
    run(0, 1'b0, 64'd0);
    run(13, 1'b1, ref_result(8, 1'b1));

    // start and writes while busy must be ignored
    load_random();
    run_start(5, 1'b0, ref_result(5, 1'b0));
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; k_len = 4'd1; usexor = 1'b1;
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd0; wr_data = ~a_m[0];
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    check("busy_mode_kept", {63'd0, dut_uio_in[1]}, 64'd0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    start = 1'b1; wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 3'd1; wr_data = ~b_m[1];
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    wait_idle();
    run(5, 1'b0, ref_result(5, 1'b0));   // operands unchanged by dropped writes

    // reset during FEED step 5 aborts the run
    load_random();
    run_start(4, 1'b1, 64'd0);
    repeat (10) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    void'(exp_q.pop_back());
    for (int i = 0; i < 8; i++) begin a_m[i] = 8'd0; b_m[i] = 8'd0; end
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_dut_rst_n", {63'd0, dut_rst_n}, 64'd0);
    check("abort_ui", {56'd0, dut_ui_in}, 64'd0);
    clr_req++;
    repeat (60) @(posedge clk);
    load_random();
    run(4, 1'b1, ref_result(4, 1'b1));

    // randomized runs
    for (int t = 0; t < 6; t++) begin
      load_random();
      k = $urandom_range(0, 11);
      m = 1'($urandom);
      run(k, m, ref_result((k > 8) ? 8 : k, m));
    end

    repeat (20) @(posedge clk);
    check("pending_runs", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
